post_code_qspi_slave: RTL and testbench

Queues POST-code writes from the LPC snoop logic and serves them, one framed entry at a time, to an external QSPI host as 4-bit nibbles. It succeeds the single-register port-80 nibble slave. This block adds:
- a parametrised code width,
- a parametrised port count,
- a FIFO of depth DEPTH, so bursts of codes are not lost,
- a tagged frame format,
- an oversampled host interface in the system clock domain.

It sits between the LPC decode block and the debug-header QSPI pins.

---
 rtl/post_code_qspi_slave.sv | 217 +++++++++++++++++++++
 tb/tb_post_code_qspi_slave.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/post_code_qspi_slave.sv
// post_code_qspi_slave: queues POST-code writes snooped from LPC and serves
// them to an external QSPI host as framed 4-bit nibbles (tag, then data MSB
// first). Host pins are oversampled in the sys_clk domain.
// Optional build macro: POST_CODE_DEDUP_EN drops a write equal to the most
// recently accepted entry.
module post_code_qspi_slave #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int NPORTS = 2
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     code_valid,
  input  logic [3:0]               code_port,
  input  logic [DATA_W-1:0]        code_data,
  input  logic                     qspi_cs_n,
  input  logic                     qspi_sck,
  output logic [3:0]               qspi_out,
  output logic                     qspi_int,
  output logic                     fifo_ovf,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int NIB = 1 + DATA_W / 4;
  localparam int EW  = 4 * NIB;
  localparam int KW  = $clog2(NIB);

  localparam logic [4:0]    NP       = 5'(NPORTS);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [KW-1:0] K_LAST   = KW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t          state, state_nxt;
  logic            cs_s1, cs_s2, cs_d;
  logic            sck_s1, sck_s2, sck_d;
  logic            cs_fall, cs_rise, sck_rise;

  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [EW-1:0]   head, entry_in;
  logic            empty, full, port_ok, dup, push_req, push, pop, drop;
  logic [LW-1:0]   level_nxt;

  logic [EW-1:0]   shift, shift_nxt;
  logic [KW-1:0]   k, k_nxt;
  logic            frame_vld, frame_vld_nxt;
  logic [3:0]      out_nxt;

  // Two-flop synchronisers plus one delay stage for edge detection
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      {cs_s1, cs_s2, cs_d}    <= '1;
      {sck_s1, sck_s2, sck_d} <= '0;
    end else begin
      cs_s1  <= qspi_cs_n;
      cs_s2  <= cs_s1;
      cs_d   <= cs_s2;
      sck_s1 <= qspi_sck;
      sck_s2 <= sck_s1;
      sck_d  <= sck_s2;
    end
  end

  assign cs_fall  = cs_d & ~cs_s2;
  assign cs_rise  = ~cs_d & cs_s2;
  assign sck_rise = sck_s2 & ~sck_d;

  // FIFO status and push qualification
  assign entry_in = {code_port, code_data};
  assign head     = mem[rd_ptr];
  assign empty    = (fifo_level == '0);
  assign full     = (fifo_level == FULL_LVL);
  assign port_ok  = code_valid && ({1'b0, code_port} < NP);

`ifdef POST_CODE_DEDUP_EN
  logic          last_vld;
  logic [EW-1:0] last_entry;

  // Remember the most recently accepted entry for duplicate suppression
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      last_vld   <= 1'b0;
      last_entry <= '0;
    end else if (push) begin
      last_vld   <= 1'b1;
      last_entry <= entry_in;
    end
  end

  assign dup = last_vld && (last_entry == entry_in);
`else
  assign dup = 1'b0;
`endif

  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept
  assign push_req = port_ok && !dup;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  // Next occupancy from the push/pop pair
  always_comb begin
    level_nxt = fifo_level;
    case ({push, pop})
      2'b10:   level_nxt = fifo_level + LW'(1);
      2'b01:   level_nxt = fifo_level - LW'(1);
      default: level_nxt = fifo_level;
    endcase
  end

  // FIFO pointers, occupancy, interrupt and sticky overflow
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      qspi_int   <= 1'b0;
      fifo_ovf   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= level_nxt;
      qspi_int   <= (level_nxt != '0);
      fifo_ovf   <= fifo_ovf | drop;
    end
  end

  // FIFO storage write port
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= entry_in;
  end

  // Host FSM state register
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Host FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = SEND;
      SEND: begin
        if (cs_rise)                        state_nxt = IDLE;
        else if (sck_rise && (k == K_LAST)) state_nxt = DONE;
      end
      DONE:    if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Host FSM outputs: frame latch, nibble index, presented nibble, pop
  always_comb begin
    out_nxt       = qspi_out;
    k_nxt         = k;
    shift_nxt     = shift;
    frame_vld_nxt = frame_vld;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        out_nxt = '0;
        k_nxt   = '0;
        if (cs_fall) begin
          frame_vld_nxt = !empty;
          shift_nxt     = empty ? '1 : head;
          out_nxt       = empty ? 4'hF : head[EW-1 -: 4];
        end
      end
      SEND: begin
        if (cs_rise) begin
          out_nxt = '0;
          k_nxt   = '0;
        end else if (sck_rise) begin
          if (k == K_LAST) begin
            out_nxt = 4'hF;
            pop     = frame_vld;
          end else begin
            k_nxt     = k + KW'(1);
            shift_nxt = {shift[EW-5:0], 4'hF};
            out_nxt   = shift[EW-5 -: 4];
          end
        end
      end
      DONE: begin
        if (cs_rise) begin
          out_nxt = '0;
          k_nxt   = '0;
        end else begin
          out_nxt = 4'hF;
        end
      end
      default: begin
        out_nxt = '0;
        k_nxt   = '0;
      end
    endcase
  end

  // Registered frame datapath and host output
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      qspi_out  <= '0;
      k         <= '0;
      shift     <= '0;
      frame_vld <= 1'b0;
    end else begin
      qspi_out  <= out_nxt;
      k         <= k_nxt;
      shift     <= shift_nxt;
      frame_vld <= frame_vld_nxt;
    end
  end

endmodule

// File: tb/tb_post_code_qspi_slave.sv
// Testbench for post_code_qspi_slave: table of directed steps, hand-written
// full-FIFO / empty-latch / reset sequences, then random traffic checked
// against a queue-based model of the FIFO and frame format.
module tb_post_code_qspi_slave;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int NPORTS = 2;
  localparam int NIB    = 1 + DATA_W / 4;
`ifdef POST_CODE_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  localparam int OP_PUSH  = 0;
  localparam int OP_FRAME = 1;

  logic              sys_clk = 1'b0;
  logic              rst;
  logic              code_valid;
  logic [3:0]        code_port;
  logic [DATA_W-1:0] code_data;
  logic              qspi_cs_n;
  logic              qspi_sck;
  logic [3:0]        qspi_out;
  logic              qspi_int;
  logic              fifo_ovf;
  logic [4:0]        fifo_level;

  post_code_qspi_slave #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NPORTS(NPORTS)) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .code_valid (code_valid),
    .code_port  (code_port),
    .code_data  (code_data),
    .qspi_cs_n  (qspi_cs_n),
    .qspi_sck   (qspi_sck),
    .qspi_out   (qspi_out),
    .qspi_int   (qspi_int),
    .fifo_ovf   (fifo_ovf),
    .fifo_level (fifo_level)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         op;
    int         port;
    int         data;
    logic [11:0] word;
    int         nrise;
    int         lvl;
    int         ovf;
  } vec_t;

  vec_t tbl[$];

  // Reference model: entries in arrival order
  logic [11:0] q[$];
  bit          m_ovf;
  bit          m_lv;
  logic [11:0] m_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  function automatic void add(input int op, input int port, input int data,
                              input logic [11:0] word, input int nrise, input int lvl);
    vec_t v;
    v.op = op; v.port = port; v.data = data; v.word = word;
    v.nrise = nrise; v.lvl = lvl; v.ovf = 0;
    tbl.push_back(v);
  endfunction

  function automatic void m_push(input int port, input int data);
    logic [11:0] e;
    e = {port[3:0], data[7:0]};
    if (port >= NPORTS) return;
    if (DEDUP && m_lv && (m_last == e)) return;
    if (q.size() == DEPTH) begin
      m_ovf = 1'b1;
      return;
    end
    q.push_back(e);
    m_lv   = 1'b1;
    m_last = e;
  endfunction

  task automatic m_check(input string tag);
    chk({tag, "_level"}, fifo_level, q.size());
    chk({tag, "_int"},   qspi_int,   (q.size() != 0));
    chk({tag, "_ovf"},   fifo_ovf,   m_ovf);
  endtask

  task automatic do_push(input int port, input int data);
    code_port  = port[3:0];
    code_data  = data[7:0];
    code_valid = 1'b1;
    @(negedge sys_clk);
    code_valid = 1'b0;
    cyc(1);
  endtask

  // Select, clock nrise sck pulses checking each nibble, deselect
  task automatic read_frame(input logic [11:0] w, input int nrise);
    logic [11:0] sh;
    qspi_cs_n = 1'b0;
    cyc(6);
    chk("nib0", qspi_out, w[11:8]);
    for (int i = 1; i <= nrise; i++) begin
      qspi_sck = 1'b1;
      cyc(6);
      if (i < NIB) begin
        sh = w >> (4 * (NIB - 1 - i));
        chk($sformatf("nib%0d", i), qspi_out, sh[3:0]);
      end else begin
        chk("done_nib", qspi_out, 4'hF);
      end
      qspi_sck = 1'b0;
      cyc(6);
    end
    qspi_cs_n = 1'b1;
    cyc(6);
    chk("idle_out", qspi_out, 4'h0);
  endtask

  task automatic model_frame(input int nrise);
    logic [11:0] exp;
    exp = (q.size() != 0) ? q[0] : 12'hFFF;
    read_frame(exp, nrise);
    if (nrise == NIB && q.size() != 0) void'(q.pop_front());
    m_check("frame");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] exp_w;
    logic [11:0] sh;
    rst        = 1'b1;
    code_valid = 1'b0;
    code_port  = '0;
    code_data  = '0;
    qspi_cs_n  = 1'b1;
    qspi_sck   = 1'b0;
    m_ovf = 1'b0; m_lv = 1'b0; m_last = '0;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    chk("rst_out",   qspi_out,   4'h0);
    chk("rst_int",   qspi_int,   1'b0);
    chk("rst_ovf",   fifo_ovf,   1'b0);
    chk("rst_level", fifo_level, 0);

    // Directed table
    add(OP_PUSH,  0,  'h5A, 12'h000, 0, 1);
    add(OP_FRAME, 0,  0,    12'h05A, 3, 0);
    add(OP_PUSH,  1,  'h3C, 12'h000, 0, 1);
    add(OP_PUSH,  0,  'h11, 12'h000, 0, 2);
    add(OP_FRAME, 0,  0,    12'h13C, 3, 1);
    add(OP_FRAME, 0,  0,    12'h011, 3, 0);
    add(OP_FRAME, 0,  0,    12'hFFF, 3, 0);
    add(OP_PUSH,  15, 'h55, 12'h000, 0, 0);
    add(OP_PUSH,  2,  'h55, 12'h000, 0, 0);
    add(OP_PUSH,  0,  'hA7, 12'h000, 0, 1);
    add(OP_FRAME, 0,  0,    12'h0A7, 1, 1);
    add(OP_FRAME, 0,  0,    12'h0A7, 3, 0);
    add(OP_PUSH,  0,  'h22, 12'h000, 0, 1);
    add(OP_PUSH,  0,  'h22, 12'h000, 0, DEDUP ? 1 : 2);
    add(OP_FRAME, 0,  0,    12'h022, 3, DEDUP ? 0 : 1);
    add(OP_FRAME, 0,  0,    DEDUP ? 12'hFFF : 12'h022, 3, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].op == OP_PUSH) begin
        do_push(tbl[i].port, tbl[i].data);
        m_push(tbl[i].port, tbl[i].data);
      end else begin
        read_frame(tbl[i].word, tbl[i].nrise);
        if (tbl[i].nrise == NIB && q.size() != 0) void'(q.pop_front());
      end
      chk($sformatf("tbl%0d_level", i), fifo_level, tbl[i].lvl);
      chk($sformatf("tbl%0d_int", i),   qspi_int,   (tbl[i].lvl != 0));
      chk($sformatf("tbl%0d_ovf", i),   fifo_ovf,   tbl[i].ovf);
    end

    // Fill to DEPTH, overflow with one more
    for (int i = 0; i < DEPTH; i++) begin
      do_push(i % 2, 'h40 + i);
      m_push(i % 2, 'h40 + i);
    end
    m_check("full");
    do_push(1, 'hEE);
    m_push(1, 'hEE);
    chk("ovf_set", fifo_ovf, 1'b1);
    m_check("ovf");

    // Complete a frame with a push landing in the same cycle as the pop
    exp_w = q[0];
    qspi_cs_n = 1'b0;
    cyc(6);
    chk("sim_nib0", qspi_out, exp_w[11:8]);
    qspi_sck = 1'b1; cyc(6);
    chk("sim_nib1", qspi_out, exp_w[7:4]);
    qspi_sck = 1'b0; cyc(6);
    qspi_sck = 1'b1; cyc(6);
    chk("sim_nib2", qspi_out, exp_w[3:0]);
    qspi_sck = 1'b0; cyc(6);
    qspi_sck = 1'b1;
    @(posedge sys_clk);
    @(posedge sys_clk);
    @(negedge sys_clk);
    code_port  = 4'd0;
    code_data  = 8'h99;
    code_valid = 1'b1;
    @(negedge sys_clk);
    code_valid = 1'b0;
    cyc(4);
    chk("sim_done", qspi_out, 4'hF);
    qspi_sck = 1'b0; cyc(6);
    qspi_cs_n = 1'b1; cyc(6);
    void'(q.pop_front());
    q.push_back(12'h099);
    m_lv = 1'b1; m_last = 12'h099;
    chk("sim_level", fifo_level, DEPTH);
    m_check("sim");
    repeat (DEPTH) model_frame(NIB);

    // Frame latched empty at select is unaffected by a push mid-frame
    qspi_cs_n = 1'b0;
    cyc(6);
    chk("lat_nib0", qspi_out, 4'hF);
    do_push(1, 'h33);
    m_push(1, 'h33);
    for (int i = 1; i <= NIB; i++) begin
      qspi_sck = 1'b1; cyc(6);
      chk($sformatf("lat_nib%0d", i), qspi_out, 4'hF);
      qspi_sck = 1'b0; cyc(6);
    end
    qspi_cs_n = 1'b1; cyc(6);
    chk("lat_level", fifo_level, 1);
    model_frame(NIB);

    // Reset in the middle of a frame
    do_push(0, 'h61);
    m_push(0, 'h61);
    qspi_cs_n = 1'b0; cyc(6);
    qspi_sck  = 1'b1; cyc(6);
    chk("rmf_nib1", qspi_out, 4'h6);
    rst       = 1'b1;
    qspi_cs_n = 1'b1;
    qspi_sck  = 1'b0;
    cyc(2);
    chk("rmf_out",   qspi_out,   4'h0);
    chk("rmf_level", fifo_level, 0);
    chk("rmf_ovf",   fifo_ovf,   1'b0);
    rst = 1'b0;
    q.delete();
    m_ovf = 1'b0; m_lv = 1'b0;
    cyc(3);
    model_frame(NIB);

    // Random traffic against the model
    for (int it = 0; it < 80; it++) begin
      int r, p, d;
      r = $urandom_range(0, 9);
      if (r < 6) begin
        p = $urandom_range(0, 3);
        d = $urandom_range(0, 7);
        do_push(p, d);
        m_push(p, d);
        m_check("rnd_push");
      end else if (r < 9) begin
        model_frame(NIB);
      end else begin
        model_frame($urandom_range(0, NIB - 1));
      end
    end
    sh = 12'h0;
    while (q.size() != 0 && sh < 12'd40) begin
      model_frame(NIB);
      sh = sh + 12'd1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
